// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, flag bit positions
// and the control FSM state type.
package alu_pkg;

   localparam logic [5:0] FUNC_ADD  = 6'b100000;
   localparam logic [5:0] FUNC_SUB  = 6'b100010;
   localparam logic [5:0] FUNC_MUL  = 6'b011000;
   localparam logic [5:0] FUNC_DIV  = 6'b011010;
   localparam logic [5:0] FUNC_AND  = 6'b100100;
   localparam logic [5:0] FUNC_OR   = 6'b100101;
   localparam logic [5:0] FUNC_NOT  = 6'b100111;
   localparam logic [5:0] FUNC_BRFL = 6'b111111;

   localparam int unsigned ABOVE    = 2;
   localparam int unsigned EQUALS   = 1;
   localparam int unsigned OVERFLOW = 0;

   // StExec is the one registered execute cycle used by every single-cycle op.
   typedef enum logic [2:0] {
      StIdle,
      StExec,
      StMul,
      StDiv,
      StDone
   } alu_state_e;

   function automatic logic is_mul_div(input logic [5:0] f);
      return (f == FUNC_MUL) || (f == FUNC_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine shared by multiply (shift-add) and divide (restoring).
// Works on operand magnitudes for WIDTH cycles, then spends one cycle applying the sign.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             is_div,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   input  logic             neg,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             ovf
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q, fix_q, div_q, neg_q;

   logic [WIDTH-1:0]   hi, lo;
   logic [WIDTH:0]     add_a, add_b, sum;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quot_signed;
   logic [WIDTH:0]     prod_top;

   assign hi = acc_q[2*WIDTH-1:WIDTH];
   assign lo = acc_q[WIDTH-1:0];

   // One adder: mul adds the multiplicand into the high half, div subtracts the divisor
   // from the partial remainder shifted left by one quotient bit.
   always_comb begin
      add_a = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
      if (div_q) begin
         add_b = ~{1'b0, opnd_q};
      end else begin
         add_b = lo[0] ? {1'b0, opnd_q} : '0;
      end
      sum = add_a + add_b + {{WIDTH{1'b0}}, div_q};
      if (div_q) begin
         if (!sum[WIDTH]) begin
            acc_d = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {add_a[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_d = {sum, lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_signed = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
      quot_signed = neg_q ? (~lo + {{(WIDTH-1){1'b0}}, 1'b1}) : lo;
      prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
      if (div_q) begin
         res = quot_signed;
         // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
         ovf = !neg_q && lo[WIDTH-1];
      end else begin
         res = prod_signed[WIDTH-1:0];
         ovf = !((&prod_top) || !(|prod_top));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         fix_q  <= 1'b0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else if (abort) begin
         busy_q <= 1'b0;
         fix_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         acc_q  <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
         opnd_q <= is_div ? mag_b : mag_a;
         div_q  <= is_div;
         neg_q  <= neg;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         fix_q  <= 1'b0;
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            busy_q <= 1'b0;
            fix_q  <= 1'b1;
            cnt_q  <= '0;
         end
      end else if (fix_q) begin
         fix_q <= 1'b0;
      end
   end

   assign busy = busy_q;
   assign done = fix_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshakes, control FSM, single-cycle ops and flag generation.
// Multiply and divide are delegated to alu_muldiv_iter.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [5:0]       func,
   input  logic [2:0]       flags_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags_out
);

   alu_state_e       state_q;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] result_q, op1_q, op2_q;
   logic [2:0]       flags_q, flags_in_q;
   logic [5:0]       func_q;

   logic             accept, div_by_zero, eng_start;
   logic [WIDTH-1:0] mag1, mag2;
   logic             eng_busy, eng_done, eng_ovf;
   logic [WIDTH-1:0] eng_res;

   logic [WIDTH-1:0] sum, diff, exec_res;
   logic             exec_ovf, exec_keep;
   logic [2:0]       exec_flags;

   function automatic logic [2:0] calc_flags(input logic [WIDTH-1:0] r, input logic v);
      logic [2:0] f;
      f[ABOVE]    = !r[WIDTH-1] && (r != '0);
      f[EQUALS]   = (r == '0);
      f[OVERFLOW] = v;
      return f;
   endfunction

   assign accept      = in_valid && in_ready_q && !flush;
   assign div_by_zero = (func == FUNC_DIV) && (op2 == '0);
   assign eng_start   = accept && is_mul_div(func) && !div_by_zero;
   assign mag1        = op1[WIDTH-1] ? (~op1 + {{(WIDTH-1){1'b0}}, 1'b1}) : op1;
   assign mag2        = op2[WIDTH-1] ? (~op2 + {{(WIDTH-1){1'b0}}, 1'b1}) : op2;

   alu_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (eng_start),
      .abort (flush),
      .is_div(func == FUNC_DIV),
      .mag_a (mag1),
      .mag_b (mag2),
      .neg   (op1[WIDTH-1] ^ op2[WIDTH-1]),
      .busy  (eng_busy),
      .done  (eng_done),
      .res   (eng_res),
      .ovf   (eng_ovf)
   );

   // A div reaching StExec is always a divide by zero: the engine was skipped.
   always_comb begin
      sum       = op1_q + op2_q;
      diff      = op1_q - op2_q;
      exec_res  = '0;
      exec_ovf  = 1'b0;
      exec_keep = 1'b0;
      case (func_q)
         FUNC_ADD: begin
            exec_res = sum;
            exec_ovf = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (sum[WIDTH-1] != op1_q[WIDTH-1]);
         end
         FUNC_SUB: begin
            exec_res = diff;
            exec_ovf = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (diff[WIDTH-1] != op1_q[WIDTH-1]);
         end
         FUNC_AND: exec_res = op1_q & op2_q;
         FUNC_OR:  exec_res = op1_q | op2_q;
         FUNC_NOT: exec_res = ~op1_q;
         FUNC_DIV: begin
            exec_res = '1;
            exec_ovf = 1'b1;
         end
         FUNC_BRFL: begin
            exec_res  = {{(WIDTH-1){1'b0}}, |(flags_in_q & op2_q[2:0])};
            exec_keep = 1'b1;
         end
         default: exec_keep = 1'b1;
      endcase
      exec_flags = exec_keep ? flags_in_q : calc_flags(exec_res, exec_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         func_q      <= '0;
         flags_in_q  <= '0;
      end else if (flush) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  op1_q      <= op1;
                  op2_q      <= op2;
                  func_q     <= func;
                  flags_in_q <= flags_in;
                  in_ready_q <= 1'b0;
                  if (func == FUNC_MUL) begin
                     state_q <= StMul;
                  end else if ((func == FUNC_DIV) && !div_by_zero) begin
                     state_q <= StDiv;
                  end else begin
                     state_q <= StExec;
                  end
               end
            end
            StExec: begin
               result_q    <= exec_res;
               flags_q     <= exec_flags;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StMul, StDiv: begin
               if (eng_done && !eng_busy) begin
                  result_q    <= eng_res;
                  flags_q     <= calc_flags(eng_res, eng_ovf);
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags_out = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results are queued when a request is driven
// and popped when out_valid rises.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, flush, out_valid, out_ready;
   logic [W-1:0] op1, op2, result;
   logic [5:0]   func;
   logic [2:0]   flags_in, flags_out;

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flags;
      logic [31:0] lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   alu_mc #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op1      (op1),
      .op2      (op2),
      .func     (func),
      .flags_in (flags_in),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [2:0] model_flags(input logic [31:0] r, input logic v);
      return {($signed(r) > 0), (r == 32'd0), v};
   endfunction

   task automatic send(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] fl, input logic [31:0] er,
                       input logic [2:0] ef, input int el);
      exp_t e;
      e.res   = er;
      e.flags = ef;
      e.lat   = el;
      exp_q.push_back(e);
      func     = f;
      op1      = a;
      op2      = b;
      flags_in = fl;
      in_valid = 1'b1;
      for (int n = 0; n < 50 && !in_ready; n++) step();
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int hold);
      exp_t e;
      int   lat = 0;
      while (!out_valid && lat < 200) begin
         step();
         lat++;
      end
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_flags"}, {29'd0, flags_out}, {29'd0, e.flags});
      chk({tag, "_latency"}, lat, e.lat);
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            func     = FUNC_ADD;
            op1      = 32'd100;
            op2      = 32'd200;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         chk({tag, "_hold_result"}, result, e.res);
         chk({tag, "_hold_flags"}, {29'd0, flags_out}, {29'd0, e.flags});
         chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int seen;
      logic [31:0] a, b, r;
      longint p;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      op1 = '0; op2 = '0; func = '0; flags_in = '0;
      repeat (2) step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, flags_out}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      send("add_ovf", FUNC_ADD, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 3'b001, 1);
      wait_result("add_ovf", 0);
      send("add_neg_ovf", FUNC_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 32'h7FFF_FFFF,
           3'b101, 1);
      wait_result("add_neg_ovf", 0);
      send("mul_neg", FUNC_MUL, -32'sd3, 32'd7, 3'b000, 32'hFFFF_FFEB, 3'b000, 33);
      wait_result("mul_neg", 0);
      send("mul_big", FUNC_MUL, 32'h1_0000, 32'h1_0000, 3'b000, 32'd0, 3'b011, 33);
      wait_result("mul_big", 0);
      send("mul_zero", FUNC_MUL, -32'sd5, 32'd0, 3'b000, 32'd0, 3'b010, 33);
      wait_result("mul_zero", 0);
      send("div_neg", FUNC_DIV, -32'sd7, 32'd2, 3'b000, 32'hFFFF_FFFD, 3'b000, 33);
      wait_result("div_neg", 0);
      send("div_zero", FUNC_DIV, 32'd5, 32'd0, 3'b000, 32'hFFFF_FFFF, 3'b001, 1);
      wait_result("div_zero", 0);
      send("div_min", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 32'h8000_0000, 3'b001, 33);
      wait_result("div_min", 0);
      send("and", FUNC_AND, 32'h0000_F0F0, 32'h0000_FF00, 3'b000, 32'h0000_F000, 3'b100, 1);
      wait_result("and", 0);
      send("or", FUNC_OR, 32'h8000_0000, 32'h0000_0001, 3'b000, 32'h8000_0001, 3'b000, 1);
      wait_result("or", 0);
      send("not", FUNC_NOT, 32'hFFFF_FFFF, 32'd0, 3'b000, 32'd0, 3'b010, 1);
      wait_result("not", 0);
      send("brfl_hit", FUNC_BRFL, 32'd9, 32'd2, 3'b010, 32'd1, 3'b010, 1);
      wait_result("brfl_hit", 0);
      send("brfl_miss", FUNC_BRFL, 32'd9, 32'd5, 3'b010, 32'd0, 3'b010, 1);
      wait_result("brfl_miss", 0);
      send("unknown", 6'b000001, 32'd4, 32'd4, 3'b101, 32'd0, 3'b101, 1);
      wait_result("unknown", 0);

      send("sub_bp", FUNC_SUB, 32'd10, 32'd3, 3'b000, 32'd7, 3'b100, 1);
      wait_result("sub_bp", 5);
      seen = 0;
      repeat (4) begin
         step();
         if (out_valid) seen++;
      end
      chk("ignored_pulse", seen, 32'd0);

      for (int i = 0; i < 4; i++) begin
         a = 32'($urandom_range(0, 400)) - 32'd200;
         b = 32'($urandom_range(0, 400)) - 32'd200;
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         send("rnd_mul", FUNC_MUL, a, b, 3'b000, r,
              model_flags(r, p != longint'($signed(r))), 33);
         wait_result("rnd_mul", 0);
         if (b == 32'd0) b = 32'd3;
         r = 32'($signed(a) / $signed(b));
         send("rnd_div", FUNC_DIV, a, b, 3'b000, r, model_flags(r, 1'b0), 33);
         wait_result("rnd_div", 0);
      end

      // Flush in the middle of a multiply: the result must never appear.
      func = FUNC_MUL; op1 = 32'd3; op2 = 32'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_idle", {31'd0, in_ready}, 32'd1);
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      seen = 0;
      repeat (40) begin
         step();
         if (out_valid) seen++;
      end
      chk("flush_quiet", seen, 32'd0);

      // Reset in the middle of a divide.
      func = FUNC_DIV; op1 = 32'd100; op2 = 32'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_flags", {29'd0, flags_out}, 32'd0);
      #10;
      rst_n = 1'b1;
      step();
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      send("post_rst_add", FUNC_ADD, 32'd2, 32'd3, 3'b000, 32'd5, 3'b100, 1);
      wait_result("post_rst_add", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
